// File: rtl/nios_accel_arb_pkg.sv
// rtl/nios_accel_arb_pkg.sv - shared constants and types for the filter-config arbiter
// Purpose: FSM state encoding, PIO register address and requester-count limit.
// Ports: none (package).
package nios_accel_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_e;

  // The filter-configuration PIO decodes only this address.
  localparam int PIO_FILTER_ADDR = 0;
  localparam int MAX_REQ         = 4;

  // Index width that stays legal for any requester count.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nios_accel_rr_picker.sv
// rtl/nios_accel_rr_picker.sv - combinational round-robin requester search
// Purpose: picks the first set request searching cyclically from rr_ptr+1.
// Ports:
//   req        in   NUM_REQ  request vector
//   rr_ptr     in   IDX_W    index of the last granted requester
//   gnt_onehot out  NUM_REQ  one-hot winner
//   gnt_idx    out  IDX_W    binary winner index
//   any_valid  out  1        at least one request present
module nios_accel_rr_picker
  import nios_accel_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any_valid
);

  // The outer loop unrolls over every possible pointer value so that all
  // request indices below are elaboration-time constants.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any_valid  = 1'b0;
    for (int p = 0; p < NUM_REQ; p++) begin
      if (int'(rr_ptr) == p) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          if (!any_valid && req[(p + k) % NUM_REQ]) begin
            any_valid                     = 1'b1;
            gnt_idx                       = IDX_W'((p + k) % NUM_REQ);
            gnt_onehot[(p + k) % NUM_REQ] = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/nios_accelerometer_filter_arbiter.sv
// rtl/nios_accelerometer_filter_arbiter.sv - round-robin arbiter for the filter-config PIO slave
// Purpose: serialises NUM_REQ Avalon-MM requesters onto one zero-latency PIO port,
//   two cycles per access (arbitrate, issue). Optional per-requester write
//   counters are built when NIOS_FILTER_ARB_WRCOUNT_EN is defined.
// Ports:
//   clk, reset_n                   clock, async active-low reset
//   s_address/s_chipselect/s_write_n/s_writedata   packed per-requester request
//   s_readdata, s_waitrequest      shared read data, per-requester stall
//   m_address/m_chipselect/m_write_n/m_writedata   registered PIO request
//   m_readdata                     PIO read data (combinational on m_address)
//   wr_count                       per-requester 16-bit write counts (macro only)
module nios_accelerometer_filter_arbiter
  import nios_accel_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ*ADDR_W-1:0] s_address,
  input  logic [NUM_REQ-1:0]        s_chipselect,
  input  logic [NUM_REQ-1:0]        s_write_n,
  input  logic [NUM_REQ*DATA_W-1:0] s_writedata,
  output logic [DATA_W-1:0]         s_readdata,
  output logic [NUM_REQ-1:0]        s_waitrequest,
`ifdef NIOS_FILTER_ARB_WRCOUNT_EN
  output logic [NUM_REQ*16-1:0]     wr_count,
`endif
  output logic [ADDR_W-1:0]         m_address,
  output logic                      m_chipselect,
  output logic                      m_write_n,
  output logic [DATA_W-1:0]         m_writedata,
  input  logic [DATA_W-1:0]         m_readdata
);

  localparam int IDX_W = idx_width(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..MAX_REQ");
  end

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   grant_idx_q;
  logic [NUM_REQ-1:0] grant_oh_q;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;

  logic [ADDR_W-1:0]  win_addr;
  logic               win_write_n;
  logic [DATA_W-1:0]  win_writedata;

  nios_accel_rr_picker #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req       (s_chipselect),
    .rr_ptr    (rr_ptr_q),
    .gnt_onehot(pick_oh),
    .gnt_idx   (pick_idx),
    .any_valid (pick_valid)
  );

  // One-hot mux of the winner's request fields.
  always_comb begin
    win_addr      = '0;
    win_write_n   = 1'b0;
    win_writedata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) begin
        win_addr      = win_addr      | s_address[i*ADDR_W +: ADDR_W];
        win_write_n   = win_write_n   | s_write_n[i];
        win_writedata = win_writedata | s_writedata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pick_valid) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The granted requester completes in the ISSUE cycle; m_write_n is still
  // the granted access's strobe there, so it selects read data vs zero.
  always_comb begin
    s_waitrequest = '1;
    s_readdata    = '0;
    if (state_q == ST_ISSUE) begin
      s_waitrequest = ~grant_oh_q;
      if (m_write_n) s_readdata = m_readdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_address    <= '0;
      m_writedata  <= '0;
      rr_ptr_q     <= IDX_W'(NUM_REQ - 1);
      grant_idx_q  <= '0;
      grant_oh_q   <= '0;
    end else if (state_q == ST_IDLE) begin
      if (pick_valid) begin
        m_chipselect <= 1'b1;
        m_write_n    <= win_write_n;
        m_address    <= win_addr;
        m_writedata  <= win_writedata;
        grant_idx_q  <= pick_idx;
        grant_oh_q   <= pick_oh;
      end else begin
        m_chipselect <= 1'b0;
        m_write_n    <= 1'b1;
      end
    end else begin
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      rr_ptr_q     <= grant_idx_q;
    end
  end

`ifdef NIOS_FILTER_ARB_WRCOUNT_EN
  logic [NUM_REQ*16-1:0] wr_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt_q <= '0;
    end else if (state_q == ST_ISSUE && !m_write_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_oh_q[i] && wr_cnt_q[i*16 +: 16] != 16'hFFFF)
          wr_cnt_q[i*16 +: 16] <= wr_cnt_q[i*16 +: 16] + 16'd1;
      end
    end
  end

  assign wr_count = wr_cnt_q;
`endif

endmodule
